// File: rtl/bch_gf_pkg.sv
// Shared definitions for the BCH decoder blocks.
//   - Default field and code constants (GF(2^5), t = 3, x^5 + x^2 + 1).
//   - Decoder state enumeration.
//   - gf_mul: combinational shift-and-reduce GF(2^m) multiply.
//     Operands are carried in GfMaxM-bit containers, so one function serves any field width
//     up to GfMaxM. The field width and polynomial are passed as arguments.
package bch_gf_pkg;

    localparam int unsigned GfMaxM = 16;
    localparam int unsigned GfM = 5;
    localparam int unsigned GfT = 3;
    localparam logic [GfMaxM:0] GfPrimPoly = 17'h00025;

    typedef enum logic [1:0] {
        StIdle,
        StDisc,
        StUpd,
        StFin
    } state_e;

    // MSB-first multiply: shift the partial product left, fold x^m back in with the
    // polynomial, then add a wherever b has a set bit.
    function automatic logic [GfMaxM-1:0] gf_mul(input logic [GfMaxM-1:0] a,
                                                 input logic [GfMaxM-1:0] b,
                                                 input int unsigned      m,
                                                 input logic [GfMaxM:0]  poly);
        logic [GfMaxM:0] p;
        p = '0;
        for (int i = GfMaxM - 1; i >= 0; i--) begin
            if (i < int'(m)) begin
                p = p << 1;
                if (p[m[4:0]]) begin
                    p = p ^ poly;
                end
                if (b[i]) begin
                    p = p ^ {1'b0, a};
                end
            end
        end
        return p[GfMaxM-1:0];
    endfunction

endpackage

// File: rtl/bch_gf_dot.sv
// Combinational GF(2^M) inner product: y = XOR over k of a_k * b_k.
// Ports:
//   a_i  N packed M-bit operands, a_k at bits [k*M +: M]
//   b_i  N packed M-bit operands, b_k at bits [k*M +: M]
//   y_o  M-bit inner product
module bch_gf_dot
    import bch_gf_pkg::*;
#(
    parameter int unsigned     M         = GfM,
    parameter int unsigned     N         = GfT + 1,
    parameter logic [GfMaxM:0] PRIM_POLY = GfPrimPoly
) (
    input  logic [N*M-1:0] a_i,
    input  logic [N*M-1:0] b_i,
    output logic [M-1:0]   y_o
);

    logic [M-1:0] acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < int'(N); k++) begin
            acc = acc ^ M'(gf_mul(GfMaxM'(a_i[k*M +: M]), GfMaxM'(b_i[k*M +: M]),
                                  M, PRIM_POLY));
        end
        y_o = acc;
    end

endmodule

// File: rtl/bch_ibm_decoder.sv
// Inversionless Berlekamp-Massey engine for binary BCH codes over GF(2^M).
// Takes 2T syndromes, runs 2T discrepancy/update iterations and returns an
// un-normalised error-locator polynomial (only its roots matter downstream).
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   start      request, sampled only while idle
//   syndromes  S_(j+1) at bits [j*M +: M], j = 0..2T-1
//   busy       high from the cycle after acceptance until done
//   done       one-cycle pulse, results valid
//   sigma      Lambda_i at bits [i*M +: M]
//   deg        final locator degree L
//   fail       L > T at completion (uncorrectable)
module bch_ibm_decoder
    import bch_gf_pkg::*;
#(
    parameter int unsigned     M         = GfM,
    parameter int unsigned     T         = GfT,
    parameter logic [GfMaxM:0] PRIM_POLY = GfPrimPoly,
    parameter int unsigned     LW        = $clog2(2 * T + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*T*M-1:0]     syndromes,
    output logic                 busy,
    output logic                 done,
    output logic [(T+1)*M-1:0]   sigma,
    output logic [LW-1:0]        deg,
    output logic                 fail
);

    localparam int unsigned PW = (T + 1) * M;
    localparam logic [PW-1:0] PolyOne = PW'(1);
    localparam logic [LW-1:0] LastR = LW'(2 * T - 1);

    state_e            state_q;
    logic [2*T*M-1:0]  synd_q;
    logic [PW-1:0]     lambda_q;
    logic [PW-1:0]     b_q;
    logic [M-1:0]      gamma_q;
    logic [M-1:0]      delta_q;
    logic [LW-1:0]     l_q;
    logic [LW-1:0]     r_q;
    logic              busy_q;
    logic              done_q;
    logic [PW-1:0]     sigma_q;
    logic [LW-1:0]     deg_q;
    logic              fail_q;

    logic [PW-1:0]     s_sel;
    logic [M-1:0]      delta_d;
    logic [PW-1:0]     b_shift;
    logic [PW-1:0]     lambda_upd;
    logic [M-1:0]      gl;
    logic [M-1:0]      db;
    logic              do_swap;
    int                l_ext;
    logic [LW-1:0]     l_new;

    // Align S_(r+1-i) with Lambda_i; indices before S_1 contribute zero.
    always_comb begin
        s_sel = '0;
        for (int i = 0; i <= int'(T); i++) begin
            if (int'(r_q) >= i) begin
                s_sel[i*M +: M] = synd_q[(int'(r_q) - i) * M +: M];
            end
        end
    end

    bch_gf_dot #(
        .M         (M),
        .N         (T + 1),
        .PRIM_POLY (PRIM_POLY)
    ) u_disc (
        .a_i (lambda_q),
        .b_i (s_sel),
        .y_o (delta_d)
    );

    // x*B: B_T falls off the top since it would only feed degree T+1.
    assign b_shift = {b_q[T*M-1:0], {M{1'b0}}};

    // Lambda' = gamma*Lambda + delta*(x*B)
    always_comb begin
        lambda_upd = '0;
        gl = '0;
        db = '0;
        for (int i = 0; i <= int'(T); i++) begin
            gl = M'(gf_mul(GfMaxM'(gamma_q), GfMaxM'(lambda_q[i*M +: M]), M, PRIM_POLY));
            db = M'(gf_mul(GfMaxM'(delta_q), GfMaxM'(b_shift[i*M +: M]), M, PRIM_POLY));
            lambda_upd[i*M +: M] = gl ^ db;
        end
    end

    assign do_swap = (delta_q != '0) && ((int'(l_q) * 2) <= int'(r_q));

    always_comb begin
        l_ext = int'(r_q) + 1 - int'(l_q);
        if (l_ext > int'(2 * T)) begin
            l_ext = int'(2 * T);
        end
        l_new = LW'(l_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            synd_q   <= '0;
            lambda_q <= PolyOne;
            b_q      <= PolyOne;
            gamma_q  <= M'(1);
            delta_q  <= '0;
            l_q      <= '0;
            r_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sigma_q  <= PolyOne;
            deg_q    <= '0;
            fail_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        synd_q   <= syndromes;
                        lambda_q <= PolyOne;
                        b_q      <= PolyOne;
                        gamma_q  <= M'(1);
                        l_q      <= '0;
                        r_q      <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StDisc;
                    end
                end
                StDisc: begin
                    delta_q <= delta_d;
                    state_q <= StUpd;
                end
                StUpd: begin
                    lambda_q <= lambda_upd;
                    if (do_swap) begin
                        b_q     <= lambda_q;
                        gamma_q <= delta_q;
                        l_q     <= l_new;
                    end else begin
                        b_q <= b_shift;
                    end
                    if (r_q == LastR) begin
                        state_q <= StFin;
                    end else begin
                        r_q     <= r_q + LW'(1);
                        state_q <= StDisc;
                    end
                end
                StFin: begin
                    sigma_q <= lambda_q;
                    deg_q   <= l_q;
                    fail_q  <= (l_q > LW'(T));
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sigma = sigma_q;
    assign deg   = deg_q;
    assign fail  = fail_q;

endmodule

// File: tb/tb_bch_ibm_decoder.sv
// Directed bench for bch_ibm_decoder, GF(2^5), t = 3.
module tb_bch_ibm_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [29:0] syndromes = '0;
    logic        busy;
    logic        done;
    logic [19:0] sigma;
    logic [2:0]  deg;
    logic        fail;

    int n_checks = 0;
    int n_pass = 0;

    // alpha^k for x^5 + x^2 + 1, k = 0..30
    logic [4:0] pow_tab [0:30];
    int         log_tab [0:31];

    bch_ibm_decoder #(
        .M         (5),
        .T         (3),
        .PRIM_POLY (17'h00025),
        .LW        (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .syndromes (syndromes),
        .busy      (busy),
        .done      (done),
        .sigma     (sigma),
        .deg       (deg),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] tb_mul(input logic [4:0] a, input logic [4:0] b);
        if (a == 5'd0 || b == 5'd0) return 5'd0;
        return pow_tab[(log_tab[a] + log_tab[b]) % 31];
    endfunction

    function automatic logic [29:0] pack6(input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [4:0] s3, input logic [4:0] s4,
                                          input logic [4:0] s5, input logic [4:0] s6);
        return {s6, s5, s4, s3, s2, s1};
    endfunction

    task automatic start_decode(input logic [29:0] s);
        syndromes = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after acceptance until done is seen; -1 if it never comes.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic decode(input logic [29:0] s, input string tag);
        int cyc;
        start_decode(s);
        wait_done(cyc);
        check_eq({tag, " latency"}, 32'(cyc), 32'd13);
    endtask

    logic [29:0] syn_single;
    logic [29:0] syn_double;
    logic [4:0]  s0;
    int          n_done;
    int          cyc_done;
    logic [19:0] cap_sigma;
    logic [2:0]  cap_deg;
    logic        busy_dropped;

    initial begin
        pow_tab = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd5, 5'd10, 5'd20, 5'd13, 5'd26,
                    5'd17, 5'd7, 5'd14, 5'd28, 5'd29, 5'd31, 5'd27, 5'd19, 5'd3, 5'd6,
                    5'd12, 5'd24, 5'd21, 5'd15, 5'd30, 5'd25, 5'd23, 5'd11, 5'd22, 5'd9,
                    5'd18};
        for (int k = 0; k < 32; k++) log_tab[k] = 0;
        for (int k = 0; k < 31; k++) log_tab[pow_tab[k]] = k;

        // Error at 3: S_j = alpha^(3j). Errors at 2,7: S_j = alpha^(2j) + alpha^(7j).
        syn_single = pack6(5'd8, 5'd10, 5'd26, 5'd14, 5'd31, 5'd3);
        syn_double = pack6(5'd16, 5'd13, 5'd18, 5'd27, 5'd1, 5'd9);

        #2 reset = 1'b1;
        #1;
        check_eq("reset sigma", 32'(sigma), 32'h1);
        check_eq("reset deg", 32'(deg), 32'd0);
        check_eq("reset fail", 32'(fail), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single error: Lambda = alpha^15 + alpha^18 x
        decode(syn_single, "single");
        check_eq("single sigma0", 32'(sigma[4:0]), 32'h1F);
        check_eq("single sigma1", 32'(sigma[9:5]), 32'h03);
        check_eq("single sigma23", 32'(sigma[19:10]), 32'h0);
        check_eq("single deg", 32'(deg), 32'd1);
        check_eq("single fail", 32'(fail), 32'd0);
        check_eq("single busy", 32'(busy), 32'd0);

        // All-zero syndromes
        decode(30'd0, "zero");
        check_eq("zero sigma", 32'(sigma), 32'h1);
        check_eq("zero deg", 32'(deg), 32'd0);
        check_eq("zero fail", 32'(fail), 32'd0);
        @(posedge clk);
        #1;
        check_eq("zero done width", 32'(done), 32'd0);
        check_eq("zero sigma hold", 32'(sigma), 32'h1);

        // Two errors, compared after scaling by sigma0
        decode(syn_double, "double");
        s0 = sigma[4:0];
        check_eq("double sigma0 nonzero", 32'(s0 != 5'd0), 32'd1);
        check_eq("double sigma1", 32'(sigma[9:5]), 32'(tb_mul(s0, 5'd16)));
        check_eq("double sigma2", 32'(sigma[14:10]), 32'(tb_mul(s0, 5'd26)));
        check_eq("double sigma3", 32'(sigma[19:15]), 32'd0);
        check_eq("double deg", 32'(deg), 32'd2);
        check_eq("double fail", 32'(fail), 32'd0);

        // Only S6 set: degree runs to 2T
        decode(pack6(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1), "overflow");
        check_eq("overflow deg", 32'(deg), 32'd6);
        check_eq("overflow fail", 32'(fail), 32'd1);

        // Second start mid-decode with other syndromes must be ignored
        start_decode(syn_single);
        n_done = 0;
        cyc_done = -1;
        cap_sigma = '0;
        cap_deg = '0;
        busy_dropped = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k < 13 && !busy) busy_dropped = 1'b1;
            if (done) begin
                n_done++;
                if (cyc_done < 0) begin
                    cyc_done = k;
                    cap_sigma = sigma;
                    cap_deg = deg;
                end
            end
            if (k == 5) begin
                syndromes = syn_double;
                start = 1'b1;
            end
            if (k == 6) begin
                start = 1'b0;
                check_eq("ignore busy", 32'(busy), 32'd1);
            end
        end
        check_eq("ignore busy held", 32'(busy_dropped), 32'd0);
        check_eq("ignore done count", 32'(n_done), 32'd1);
        check_eq("ignore latency", 32'(cyc_done), 32'd13);
        check_eq("ignore sigma", 32'(cap_sigma), 32'h7F);
        check_eq("ignore deg", 32'(cap_deg), 32'd1);
        check_eq("ignore idle", 32'(busy), 32'd0);

        // Reset mid-decode, then a clean decode
        start_decode(syn_double);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("abort sigma", 32'(sigma), 32'h1);
        check_eq("abort deg", 32'(deg), 32'd0);
        check_eq("abort fail", 32'(fail), 32'd0);
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort done", 32'(done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check_eq("abort no done", 32'(n_done), 32'd0);
        decode(syn_single, "post-reset");
        check_eq("post-reset sigma", 32'(sigma), 32'h7F);
        check_eq("post-reset deg", 32'(deg), 32'd1);
        check_eq("post-reset fail", 32'(fail), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
